// File: rtl/fpu_seq_ctrl.sv
// FPU sequencer: runs FLW, FSW and NUM_FU start/done arithmetic units, one op in flight.
// Optional sticky overflow flag is compiled in with `define FPU_FFLAGS_EN.
module fpu_seq_ctrl #(
    parameter int XLEN        = 32,
    parameter int NUM_FU      = 3,
    parameter int LOAD_SETTLE = 2,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enabled,
    input  logic                   instr_flw,
    input  logic                   instr_fsw,
    input  logic [NUM_FU-1:0]      instr_fop,
    input  logic [XLEN-1:0]        reg_rs1,
    input  logic [XLEN-1:0]        freg_rs1,
    input  logic [XLEN-1:0]        freg_rs2,
    input  logic [4:0]             frd_addr,
    input  logic [XLEN-1:0]        imm,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_wdata,
    input  logic [XLEN-1:0]        mem_rdata,
    output logic                   mem_re,
    output logic                   mem_we,
    input  logic                   mem_ready,
    output logic [NUM_FU-1:0]      fu_start,
    output logic [XLEN-1:0]        fu_x1,
    output logic [XLEN-1:0]        fu_x2,
    input  logic [NUM_FU-1:0]      fu_done,
    input  logic [NUM_FU*XLEN-1:0] fu_result,
    input  logic [NUM_FU-1:0]      fu_ovf,
    output logic                   freg_wb_enable,
    output logic [4:0]             freg_wb_addr,
    output logic [XLEN-1:0]        freg_wb_data,
    output logic                   completed,
    output logic                   fpu_busy,
    output logic                   fpu_error,
    input  logic                   fflags_clr,
    output logic                   fflags_of
);
    localparam int SEL_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_MAX = (MEM_TIMEOUT > LOAD_SETTLE) ? MEM_TIMEOUT : LOAD_SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, SETTLE, FU_START, FU_WAIT, DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_FU} op_t;

    state_t            state_reg;
    op_t               op_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [4:0]        frd_reg;
    logic [XLEN-1:0]   mem_addr_reg, mem_wdata_reg, fu_x1_reg, fu_x2_reg, wb_data_reg;
    logic [4:0]        wb_addr_reg;
    logic              mem_re_reg, mem_we_reg, wb_en_reg, completed_reg, error_reg;
    logic [NUM_FU-1:0] fu_start_reg;

    logic [NUM_FU-1:0] pick_onehot;
    logic [SEL_W-1:0]  pick_idx;
    logic [CNT_W-1:0]  cnt_inc;
    logic              any_sel, fu_done_sel, timeout_hit, go_done, go_err;
    logic [XLEN-1:0]   fu_result_sel;

    // Lowest-index requested unit wins among the arithmetic selects.
    genvar gi;
    for (gi = 0; gi < NUM_FU; gi++) begin : g_pick
        if (gi == 0) begin : g_first
            assign pick_onehot[gi] = instr_fop[gi];
        end else begin : g_rest
            assign pick_onehot[gi] = instr_fop[gi] & ~(|instr_fop[gi-1:0]);
        end
    end

    always_comb begin
        pick_idx = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (instr_fop[i]) pick_idx = SEL_W'(i);
        end
    end

    assign any_sel       = instr_flw | instr_fsw | (|instr_fop);
    assign cnt_inc       = cnt_reg + 1'b1;
    assign fu_done_sel   = fu_done[sel_reg];
    assign fu_result_sel = fu_result[int'(sel_reg)*XLEN +: XLEN];
    assign timeout_hit   = (MEM_TIMEOUT != 0) && (int'(cnt_inc) == MEM_TIMEOUT);

    always_comb begin
        go_done = 1'b0;
        go_err  = 1'b0;
        case (state_reg)
            MEM_WAIT: begin
                if (mem_ready) begin
                    go_done = (op_reg == OP_STORE);
                end else if (timeout_hit) begin
                    go_done = 1'b1;
                    go_err  = 1'b1;
                end
            end
            SETTLE:  go_done = (cnt_reg == CNT_W'(LOAD_SETTLE - 1));
            FU_WAIT: go_done = fu_done_sel;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= OP_LOAD;
            sel_reg       <= '0;
            cnt_reg       <= '0;
            frd_reg       <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            fu_x1_reg     <= '0;
            fu_x2_reg     <= '0;
            wb_data_reg   <= '0;
            wb_addr_reg   <= '0;
            mem_re_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            wb_en_reg     <= 1'b0;
            completed_reg <= 1'b0;
            error_reg     <= 1'b0;
            fu_start_reg  <= '0;
        end else begin
            mem_re_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            fu_start_reg  <= '0;
            wb_en_reg     <= 1'b0;
            completed_reg <= 1'b0;
            error_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enabled && any_sel) begin
                        mem_addr_reg  <= reg_rs1 + imm;
                        mem_wdata_reg <= freg_rs2;
                        fu_x1_reg     <= freg_rs1;
                        fu_x2_reg     <= freg_rs2;
                        frd_reg       <= frd_addr;
                        sel_reg       <= pick_idx;
                        if (instr_flw) begin
                            op_reg     <= OP_LOAD;
                            mem_re_reg <= 1'b1;
                            state_reg  <= MEM_REQ;
                        end else if (instr_fsw) begin
                            op_reg     <= OP_STORE;
                            mem_we_reg <= 1'b1;
                            state_reg  <= MEM_REQ;
                        end else begin
                            op_reg       <= OP_FU;
                            fu_start_reg <= pick_onehot;
                            state_reg    <= FU_START;
                        end
                    end
                end
                MEM_REQ: begin
                    cnt_reg   <= '0;
                    state_reg <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        cnt_reg   <= '0;
                        state_reg <= SETTLE;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                SETTLE: begin
                    cnt_reg <= cnt_inc;
                    if (go_done) wb_data_reg <= mem_rdata;
                end
                FU_START: state_reg <= FU_WAIT;
                FU_WAIT: begin
                    if (fu_done_sel) wb_data_reg <= fu_result_sel;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            // Completion overrides any state move chosen above.
            if (go_done) begin
                state_reg     <= DONE;
                completed_reg <= 1'b1;
                error_reg     <= go_err;
                wb_en_reg     <= !go_err && (op_reg != OP_STORE);
                wb_addr_reg   <= frd_reg;
            end
        end
    end

    assign mem_addr       = mem_addr_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign mem_re         = mem_re_reg;
    assign mem_we         = mem_we_reg;
    assign fu_start       = fu_start_reg;
    assign fu_x1          = fu_x1_reg;
    assign fu_x2          = fu_x2_reg;
    assign freg_wb_enable = wb_en_reg;
    assign freg_wb_addr   = wb_addr_reg;
    assign freg_wb_data   = wb_data_reg;
    assign completed      = completed_reg;
    assign fpu_error      = error_reg;
    assign fpu_busy       = (state_reg != IDLE);

`ifdef FPU_FFLAGS_EN
    logic fflags_of_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_of_reg <= 1'b0;
        end else if (state_reg == FU_WAIT && fu_done_sel && fu_ovf[sel_reg]) begin
            fflags_of_reg <= 1'b1;
        end else if (fflags_clr) begin
            fflags_of_reg <= 1'b0;
        end
    end
    assign fflags_of = fflags_of_reg;
`else
    logic unused_fflags;
    assign unused_fflags = ^{fflags_clr, fu_ovf};
    assign fflags_of     = 1'b0;
`endif
endmodule
